// File: rtl/reg_pkg.sv
// Shared definitions for register readout blocks.
//   state_e : serial reader FSM states (IDLE, SHIFT, DONE), 2-bit encoding
//   REG_W   : default register word width
package reg_pkg;

  localparam int REG_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down-counter that tracks which bit of a word is being read out.
// Ports:
//   clk        : clock, all updates on posedge
//   rst_n      : asynchronous active-low clear
//   load_i     : load load_val_i; takes priority over dec_i
//   load_val_i : value to load
//   dec_i      : decrement by one; saturates at zero
//   zero_o     : count is zero
module bit_down_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/reg_serial_reader.sv
// Captures a parallel register word and streams it out MSB-first, one bit
// per valid/ready transfer, then pulses done for one cycle.
// Ports:
//   clk        : clock
//   reset      : asynchronous active-low reset
//   d          : parallel word, sampled only at the capture edge
//   load_valid : capture request; load_ready : accepting captures (IDLE)
//   sout       : current serial bit; sout_valid : bit valid (SHIFT)
//   sout_ready : sink accepts the bit; sout_last : bit 0 of the word
//   done       : one-cycle pulse after the last transfer; busy : in SHIFT
module reg_serial_reader
  import reg_pkg::*;
#(
  parameter int WIDTH = REG_W,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             done,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;

  bit_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (cnt_load),
    .load_val_i (CNT_TOP),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          shreg_d  = d;
          cnt_load = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (sout_ready) begin
          if (cnt_zero) begin
            state_d = DONE;
          end else begin
            shreg_d = shreg_q << 1;
            cnt_dec = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  // Every output is a decode of registered state. The shift register keeps
  // its last MSB after a word, so sout is gated to read 0 outside SHIFT.
  assign load_ready = (state_q == IDLE);
  assign sout_valid = (state_q == SHIFT);
  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign sout       = (state_q == SHIFT) && shreg_q[WIDTH-1];
  assign sout_last  = (state_q == SHIFT) && cnt_zero;

endmodule

// File: tb/tb_reg_serial_reader.sv
module tb_reg_serial_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] d;
  logic        load_valid;
  logic        load_ready;
  logic        sout;
  logic        sout_valid;
  logic        sout_ready;
  logic        sout_last;
  logic        done;
  logic        busy;

  int tests = 0;
  int fails = 0;

  reg_serial_reader #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .sout_last  (sout_last),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one word for a single cycle; DUT must be in IDLE.
  task automatic do_load(input logic [31:0] val);
    d = val;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  // Consumes a word from the serial side. Stalls the sink for stall_len
  // cycles once stall_at bits have been taken. cyc_done counts cycles with
  // the load cycle as cycle 1.
  task automatic read_word(input int stall_at, input int stall_len,
                           output logic [31:0] w, output int nbits,
                           output int last_errs, output int hold_errs,
                           output int cyc_done, output bit timeout);
    int   stall_cnt;
    bit   was_stalled;
    logic prev_sout;
    logic prev_last;
    w = '0; nbits = 0; last_errs = 0; hold_errs = 0; cyc_done = 0;
    timeout = 1'b1; stall_cnt = 0; was_stalled = 1'b0;
    prev_sout = 1'b0; prev_last = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (done) begin
        cyc_done = cyc + 1;
        timeout = 1'b0;
        return;
      end
      if (sout_valid) begin
        if (was_stalled && (sout !== prev_sout || sout_last !== prev_last))
          hold_errs++;
        prev_sout = sout;
        prev_last = sout_last;
        if (nbits == stall_at && stall_cnt < stall_len) begin
          sout_ready = 1'b0;
          stall_cnt++;
          was_stalled = 1'b1;
        end else begin
          sout_ready = 1'b1;
          was_stalled = 1'b0;
          w = {w[30:0], sout};
          nbits++;
          if (sout_last !== (nbits == 32)) last_errs++;
        end
      end else begin
        sout_ready = 1'b1;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; d = '0; load_valid = 1'b0; sout_ready = 1'b0;
    #1;
    tick(); tick();
    tests++;
    if ({load_ready, sout, sout_valid, sout_last, done, busy} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 100000",
               {load_ready, sout, sout_valid, sout_last, done, busy});
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    tests++;
    if (load_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: load_ready=%b busy=%b expected 1 0", load_ready, busy);
    end
    $display("[TB] reset: checked");
  endtask

  task automatic test_basic;
    logic [31:0] w; int nb, le, he, cd; bit to;
    sout_ready = 1'b1;
    do_load(32'hA213D22F);
    tests++;
    if (sout_valid !== 1'b1 || sout !== 1'b1 || busy !== 1'b1 || load_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_first_bit: valid=%b sout=%b busy=%b ready=%b expected 1 1 1 0",
               sout_valid, sout, busy, load_ready);
    end
    read_word(-1, 0, w, nb, le, he, cd, to);
    tests++;
    if (to) begin fails++; $display("FAIL basic_timeout: no done pulse expected by cycle 34"); end
    tests++;
    if (w !== 32'hA213D22F || nb != 32) begin
      fails++;
      $display("FAIL basic_word: got %h (%0d bits) expected a213d22f (32 bits)", w, nb);
    end
    tests++;
    if (le != 0) begin fails++; $display("FAIL basic_last: %0d bad sout_last cycles expected 0", le); end
    tests++;
    if (cd != 34) begin fails++; $display("FAIL basic_done_cycle: got %0d expected 34", cd); end
    tests++;
    if (sout_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_done_outputs: valid=%b busy=%b ready=%b expected 0 0 0",
               sout_valid, busy, load_ready);
    end
    tick();
    tests++;
    if (load_ready !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle_after: load_ready=%b done=%b expected 1 0", load_ready, done);
    end
    $display("[TB] basic: word %h done at cycle %0d", w, cd);
  endtask

  task automatic test_stall;
    logic [31:0] w; int nb, le, he, cd; bit to;
    do_load(32'h3324DFA1);
    read_word(3, 5, w, nb, le, he, cd, to);
    tests++;
    if (to || w !== 32'h3324DFA1 || nb != 32) begin
      fails++;
      $display("FAIL stall_word: got %h (%0d bits, timeout=%0d) expected 3324dfa1", w, nb, to);
    end
    tests++;
    if (he != 0 || le != 0) begin
      fails++;
      $display("FAIL stall_hold: hold_errs=%0d last_errs=%0d expected 0 0", he, le);
    end
    tests++;
    if (cd != 39) begin fails++; $display("FAIL stall_done_cycle: got %0d expected 39", cd); end
    tick();
    $display("[TB] stall: word %h done at cycle %0d", w, cd);
  endtask

  task automatic test_load_busy;
    logic [31:0] w; int nb, le, he, cd; bit to;
    do_load(32'h12353ABC);
    sout_ready = 1'b0;
    d = 32'hFFFFFFFF;
    load_valid = 1'b1;
    tick(); tick();
    tests++;
    if (load_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_ready: load_ready=%b busy=%b expected 0 1", load_ready, busy);
    end
    load_valid = 1'b0;
    read_word(-1, 0, w, nb, le, he, cd, to);
    tests++;
    if (to || w !== 32'h12353ABC || nb != 32) begin
      fails++;
      $display("FAIL busy_word: got %h (%0d bits) expected 12353abc", w, nb);
    end
    tick();
    $display("[TB] load_busy: word %h", w);
  endtask

  task automatic test_input_change;
    logic [31:0] w; int nb, le, he, cd; bit to;
    do_load(32'h00000001);
    d = 32'h80000000;
    read_word(-1, 0, w, nb, le, he, cd, to);
    tests++;
    if (to || w !== 32'h00000001 || le != 0) begin
      fails++;
      $display("FAIL input_change_word: got %h last_errs=%0d expected 00000001 0", w, le);
    end
    tick();
    $display("[TB] input_change: word %h", w);
  endtask

  task automatic test_reset_mid;
    bit saw;
    sout_ready = 1'b1;
    do_load(32'hDEADBEEF);
    repeat (10) tick();
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if ({load_ready, sout, sout_valid, sout_last, done, busy} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_mid_async: got %b expected 100000",
               {load_ready, sout, sout_valid, sout_last, done, busy});
    end
    tick();
    @(negedge clk);
    reset = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
    end
    tests++;
    if (saw || load_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_after: stray done/busy=%0d load_ready=%b expected 0 1", saw, load_ready);
    end
    $display("[TB] reset_mid: checked");
  endtask

  task automatic test_back_to_back;
    logic [63:0] w64; int nb, ncap, cap1, cap2, d1, d2;
    w64 = '0; nb = 0; ncap = 0; cap1 = 0; cap2 = 0; d1 = 0; d2 = 0;
    sout_ready = 1'b1;
    d = 32'hAAAAAAAA;
    load_valid = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      if (load_ready) begin
        ncap++;
        if (ncap == 1) cap1 = k; else cap2 = k;
      end
      if (sout_valid) begin w64 = {w64[62:0], sout}; nb++; end
      if (done) begin
        if (d1 == 0) d1 = k;
        else begin d2 = k; break; end
      end
      tick();
      if (ncap == 1) d = 32'h55555555;
      if (ncap >= 2) load_valid = 1'b0;
    end
    load_valid = 1'b0;
    tests++;
    if (d2 == 0) begin fails++; $display("FAIL b2b_timeout: second done not seen in 100 cycles"); end
    tests++;
    if (cap1 != 1 || cap2 != 35) begin
      fails++;
      $display("FAIL b2b_capture: got cycles %0d,%0d expected 1,35", cap1, cap2);
    end
    tests++;
    if (d1 != 34 || d2 != 68) begin
      fails++;
      $display("FAIL b2b_done: got cycles %0d,%0d expected 34,68", d1, d2);
    end
    tests++;
    if (w64 !== 64'hAAAAAAAA55555555 || nb != 64) begin
      fails++;
      $display("FAIL b2b_words: got %h (%0d bits) expected aaaaaaaa55555555", w64, nb);
    end
    tick();
    $display("[TB] back_to_back: done at %0d and %0d", d1, d2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_load_busy();
    test_input_change();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_serial_reader.md
Name: reg_serial_reader

Overview:
- Reader-side counterpart to the team's 32-bit DFF register: captures a parallel register word and streams it out MSB-first, one bit per transfer.
- Sits between a register's q output and a 1-bit serial sink, for debug readout or a scan-style link.
- Uses a valid/ready handshake on both the load side and the serial side, so the sink may stall the stream.

Parameters:
- WIDTH, 32, register word width in bits; legal range is 2 to 64.
- CNT_W, $clog2(WIDTH), width of the bit-index counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; asserting low clears all state immediately.
- d  in  WIDTH  parallel register value to read out.
- load_valid  in  1  request to capture d.
- load_ready  out  1  block can accept a capture; high only in IDLE.
- sout  out  1  current serial bit, MSB first.
- sout_valid  out  1  sout holds a valid bit.
- sout_ready  in  1  sink accepts sout this cycle.
- sout_last  out  1  current bit is bit 0 of the word.
- done  out  1  single-cycle pulse after the last bit transfers.
- busy  out  1  high in SHIFT.

Behaviour:
- Reset (async, while reset==0):
  - state=IDLE, shreg=0, cnt=0.
  - sout=0, sout_valid=0, sout_last=0, done=0, busy=0, load_ready=1.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready=1.
  - Capture fires on a posedge with load_valid&&load_ready: shreg<=d, cnt<=WIDTH-1, state<=SHIFT.
  - Load-to-first-valid latency is 1 cycle: sout_valid goes high in the cycle after the capture.
- SHIFT:
  - sout_valid=1, busy=1, load_ready=0.
  - sout=shreg[WIDTH-1]; sout_last=(cnt==0).
  - A transfer is a posedge with sout_valid&&sout_ready.
  - On a transfer with cnt!=0: shreg<=shreg<<1 (zero fill), cnt<=cnt-1.
  - On a transfer with cnt==0: state<=DONE.
  - sout_ready=0 stalls: sout, sout_last and cnt hold their values unchanged for any number of cycles.
- DONE:
  - Lasts exactly 1 cycle: done=1, sout_valid=0, busy=0, load_ready=0; then state<=IDLE.
  - The next capture is possible no earlier than 2 cycles after the last transfer.
- Throughput: with sout_ready held high, one word takes 1 (load) + WIDTH (shift) + 1 (done) cycles; 34 cycles at WIDTH=32.
- Boundary conditions:
  - load_valid while busy or in DONE is ignored; no capture and no side effect. The source must hold load_valid until load_ready is high.
  - d is sampled only at the capture edge. Later changes to d do not affect the word already being shifted.
  - sout_ready high in IDLE or DONE has no effect.
  - Reset asserted mid-SHIFT aborts the word: done is not pulsed, and the state after release is IDLE.
  - Reset release is asynchronous-assert / synchronous-deassert at the system level. The block makes no assumption beyond the async clear.
- Outputs come from registers or decodes of the state register only. sout, sout_last and load_ready have no combinational path from sout_ready or load_valid.

Decomposition:
- Shared package reg_pkg holds:
  - the state enum {IDLE, SHIFT, DONE} as a 2-bit typedef;
  - a localparam REG_W=32 used as the WIDTH default;
  - no other typedefs.
- One sub-module is natural: bit_down_counter (CNT_W bits, load/dec/zero flag), shared with future readout blocks.
- The shift register and FSM stay inline.

Test Plan:
- Basic readout: reset low 2 cycles then high; load d=32'hA213D22F with sout_ready=1. Expect sout sequence 1,0,1,0,0,0,1,0,… (MSB first), sout_last only on the 32nd bit, done pulse at cycle 34 after the load, then load_ready=1.
- Stall: load 32'h3324DFA1; drop sout_ready for 5 cycles after bit 3. Expect sout and sout_last held, no bit skipped or duplicated, and the full reassembled word equal to 32'h3324DFA1.
- Load while busy: during SHIFT of 32'h12353ABC, pulse load_valid with d=32'hFFFFFFFF. Expect it ignored and the output word 32'h12353ABC.
- Input change after capture: load 32'h00000001, then change d to 32'h80000000 the next cycle. Expect 31 zeros, then a 1 with sout_last=1.
- Reset mid-operation: assert reset low after 10 bits of 32'hDEADBEEF. Expect all outputs at reset values immediately (asynchronously), no done pulse, and load_ready=1 after release.
- Back-to-back: hold load_valid high with 32'hAAAAAAAA then 32'h55555555. Expect the second capture exactly 1 cycle after done, giving a 68-cycle total for two words.
